branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/btb_pkg.sv | 21 ++
 rtl/branch_target_buffer_sat_counter.sv | 27 ++
 rtl/branch_target_buffer.sv | 157 +++++++++++++++
 tb/tb_branch_target_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: counter encodings,
// allocation value and sequential PC step.
package btb_pkg;

    // Sequential fetch advances one 32-bit instruction.
    localparam int unsigned PC_INC = 4;

    // Two-bit predictor states, strongly not taken through strongly taken.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr2_e;

    // Weakly-taken value for a counter of the given width: MSB set, rest clear.
    function automatic int unsigned weakly_taken(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 32'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter.sv
// Saturating up/down counter next-state logic for the predictor counters.
module sat_counter #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_next_c_o
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    // Step toward taken or not taken, holding at either end.
    always_comb begin
        ctr_next_c_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_MAX) begin
                ctr_next_c_o = ctr_i + CTR_W'(1);
            end
        end else begin
            if (ctr_i != CTR_MIN) begin
                ctr_next_c_o = ctr_i - CTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters,
// mispredict detection/recovery and a saturating mispredict statistic.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 128,
    parameter int unsigned AW      = 32,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    // fetch-side lookup
    input  logic [AW-1:0]    if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [AW-1:0]    pred_target,
    // resolved-branch update
    input  logic             upd_valid,
    input  logic [AW-1:0]    upd_pc,
    input  logic [AW-1:0]    upd_target,
    input  logic             upd_taken,
    input  logic             upd_pred_taken,
    input  logic [AW-1:0]    upd_pred_target,
    input  logic             flush_all,
    // recovery and statistics
    output logic             mispredict,
    output logic [AW-1:0]    recover_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned      IDX_W     = $clog2(ENTRIES);
    localparam int unsigned      TAG_W     = AW - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(weakly_taken(CTR_W));
    localparam logic [AW-1:0]    PC_STEP   = AW'(PC_INC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Entry storage; only the valid bits are reset.
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [AW-1:0]      target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Lookup decode
    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic               if_match;

    // Update decode and write controls
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic               commit;
    logic               hit_wr;
    logic               alloc_wr;
    logic               ctr_wr;
    logic               tgt_wr;
    logic [CTR_W-1:0]   upd_ctr;
    logic [CTR_W-1:0]   ctr_next;
    logic [CTR_W-1:0]   ctr_wdata;

    // Word-offset bits never participate in index or tag.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup path: reads registered state only, no bypass from the update port.
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[AW-1:IDX_W+2];
    assign if_match    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_hit    = reset_n && if_match;
    assign pred_taken  = pred_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + PC_STEP);

    // Update path decode; reset and flush both suppress any write.
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[AW-1:IDX_W+2];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign commit    = reset_n && !flush_all && upd_valid;
    assign hit_wr    = commit && upd_hit;
    assign alloc_wr  = commit && !upd_hit && upd_taken;
    assign ctr_wr    = hit_wr || alloc_wr;
    assign tgt_wr    = (hit_wr && upd_taken) || alloc_wr;
    assign upd_ctr   = ctr_q[upd_idx];
    assign ctr_wdata = alloc_wr ? CTR_ALLOC : ctr_next;

    sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr_i        (upd_ctr),
        .inc_i        (upd_taken),
        .ctr_next_c_o (ctr_next)
    );

    // Valid next state: flush clears everything, allocation sets one entry.
    always_comb begin
        valid_d = valid_q;
        if (flush_all) begin
            valid_d = '0;
        end else if (alloc_wr) begin
            valid_d[upd_idx] = 1'b1;
        end
    end

    // Valid bits register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag, target and counter arrays: written only on a committed update.
    always_ff @(posedge clk) begin
        if (alloc_wr) begin
            tag_q[upd_idx] <= upd_tag;
        end
        if (tgt_wr) begin
            target_q[upd_idx] <= upd_target;
        end
        if (ctr_wr) begin
            ctr_q[upd_idx] <= ctr_wdata;
        end
    end

    // Mispredict: wrong direction, or taken with a wrong target.
    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    // Correct next PC for the resolved branch.
    assign recover_pc = upd_taken ? upd_target : (upd_pc + PC_STEP);

    // Mispredict statistic next state, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Mispredict statistic register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: vector table plus hand-written
// saturation and reset sequences, compared through an expected-value queue.
module tb_branch_target_buffer;

    localparam int unsigned CNT_W = 4;

    localparam logic [31:0] PA  = 32'h0040_0010;  // index 4
    localparam logic [31:0] PA4 = 32'h0040_0014;
    localparam logic [31:0] PB  = 32'h0040_0210;  // alias of PA
    localparam logic [31:0] PB4 = 32'h0040_0214;
    localparam logic [31:0] PC  = 32'h0040_0020;  // index 8
    localparam logic [31:0] PC4 = 32'h0040_0024;
    localparam logic [31:0] TA  = 32'h0040_0100;
    localparam logic [31:0] TB  = 32'h0040_0300;
    localparam logic [31:0] TC  = 32'h0040_0400;
    localparam logic [31:0] PW  = 32'hFFFF_FFFC;

    typedef struct {
        logic             hit;
        logic             tk;
        logic [31:0]      tgt;
        logic             mp;
        logic [31:0]      rec;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] if_pc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic        uptk;
        logic [31:0] uptgt;
        logic        fl;
        exp_t        e;
    } vec_t;

    logic             clk;
    logic             reset_n;
    logic [31:0]      if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic             upd_pred_taken;
    logic [31:0]      upd_pred_target;
    logic             flush_all;
    logic             mispredict;
    logic [31:0]      recover_pc;
    logic [CNT_W-1:0] mispredict_cnt;

    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    exp_t sb_q[$];

    branch_target_buffer #(
        .ENTRIES (128),
        .AW      (32),
        .CTR_W   (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_pc           (if_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .flush_all       (flush_all),
        .mispredict      (mispredict),
        .recover_pc      (recover_pc),
        .mispredict_cnt  (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic [31:0] ipc, input logic uv,
        input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
        input logic uptk, input logic [31:0] uptgt, input logic fl,
        input logic ehit, input logic etk, input logic [31:0] etgt,
        input logic emp, input logic [31:0] erec, input logic [CNT_W-1:0] ecnt);
        vec_t v;
        v.rst_n = rst;  v.if_pc = ipc; v.uv = uv;   v.upc = upc;
        v.utgt  = utgt; v.utk   = utk; v.uptk = uptk; v.uptgt = uptgt;
        v.fl    = fl;
        v.e.hit = ehit; v.e.tk = etk; v.e.tgt = etgt;
        v.e.mp  = emp;  v.e.rec = erec; v.e.cnt = ecnt;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one vector after the rising edge, queue its expectation, and
    // compare the popped expectation against outputs sampled at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        reset_n         = v.rst_n;
        if_pc           = v.if_pc;
        upd_valid       = v.uv;
        upd_pc          = v.upc;
        upd_target      = v.utgt;
        upd_taken       = v.utk;
        upd_pred_taken  = v.uptk;
        upd_pred_target = v.uptgt;
        flush_all       = v.fl;
        sb_q.push_back(v.e);
        @(negedge clk);
        e = sb_q.pop_front();
        cmp({tag, ".pred_hit"},       32'(pred_hit),       32'(e.hit));
        cmp({tag, ".pred_taken"},     32'(pred_taken),     32'(e.tk));
        cmp({tag, ".pred_target"},    pred_target,         e.tgt);
        cmp({tag, ".mispredict"},     32'(mispredict),     32'(e.mp));
        cmp({tag, ".recover_pc"},     recover_pc,          e.rec);
        cmp({tag, ".mispredict_cnt"}, 32'(mispredict_cnt), 32'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time bound");
        $fatal(1);
    end

    initial begin
        int exp_cnt;
        n_cmp = 0;
        n_bad = 0;

        //              rst ifpc uv upc  utgt utk uptk uptgt fl | hit tk tgt  mp rec  cnt
        tbl.push_back(mk(0, PA,  0, 0,   0,   0,  0,   0,    0,   0,  0, PA4, 0, 4,   0)); // in reset
        tbl.push_back(mk(1, PA,  0, 0,   0,   0,  0,   0,    0,   0,  0, PA4, 0, 4,   0)); // after reset
        tbl.push_back(mk(1, PA,  1, PA,  TA,  1,  0,   0,    0,   0,  0, PA4, 1, TA,  0)); // alloc, no bypass
        tbl.push_back(mk(1, PA,  0, 0,   0,   0,  0,   0,    0,   1,  1, TA,  0, 4,   1)); // WT
        tbl.push_back(mk(1, PA,  1, PA,  0,   0,  1,   TA,   0,   1,  1, TA,  1, PA4, 1)); // WT->WNT
        tbl.push_back(mk(1, PA,  1, PA,  0,   0,  0,   0,    0,   1,  0, PA4, 0, PA4, 2)); // WNT->SNT
        tbl.push_back(mk(1, PA,  1, PA,  0,   0,  0,   0,    0,   1,  0, PA4, 0, PA4, 2)); // SNT holds
        tbl.push_back(mk(1, PA,  1, PA,  TA,  1,  0,   0,    0,   1,  0, PA4, 1, TA,  2)); // SNT->WNT
        tbl.push_back(mk(1, PA,  1, PA,  TA,  1,  1,   TA,   0,   1,  0, PA4, 0, TA,  3)); // WNT->WT
        tbl.push_back(mk(1, PA,  1, PA,  TA,  1,  1,   TA,   0,   1,  1, TA,  0, TA,  3)); // WT->ST
        tbl.push_back(mk(1, PA,  1, PA,  TA,  1,  1,   TA,   0,   1,  1, TA,  0, TA,  3)); // ST holds
        tbl.push_back(mk(1, PA,  1, PA,  0,   0,  1,   TA,   0,   1,  1, TA,  1, PA4, 3)); // ST->WT
        tbl.push_back(mk(1, PA,  1, PA,  TC,  1,  1,   TA,   0,   1,  1, TA,  1, TC,  4)); // wrong target
        tbl.push_back(mk(1, PA,  1, PB,  TB,  1,  0,   0,    0,   1,  1, TC,  1, TB,  5)); // alias replaces
        tbl.push_back(mk(1, PA,  0, 0,   0,   0,  0,   0,    0,   0,  0, PA4, 0, 4,   6)); // old tag gone
        tbl.push_back(mk(1, PB,  1, PA,  0,   0,  0,   0,    0,   1,  1, TB,  0, PA4, 6)); // miss NT: no-op
        tbl.push_back(mk(1, PB,  0, 0,   0,   0,  0,   0,    0,   1,  1, TB,  0, 4,   6));
        tbl.push_back(mk(1, PB,  1, PC,  TA,  1,  0,   0,    1,   1,  1, TB,  1, TA,  6)); // flush + update
        tbl.push_back(mk(1, PC,  0, 0,   0,   0,  0,   0,    0,   0,  0, PC4, 0, 4,   7)); // no allocation
        tbl.push_back(mk(1, PB,  0, 0,   0,   0,  0,   0,    0,   0,  0, PB4, 0, 4,   7)); // flushed
        tbl.push_back(mk(1, PW,  0, PW,  0,   0,  0,   0,    0,   0,  0, 0,   0, 0,   7)); // PC wrap
        tbl.push_back(mk(1, PA,  0, PA,  TA,  1,  0,   0,    0,   0,  0, PA4, 0, TA,  7)); // no valid, no mp

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // 20 back-to-back mispredicts on a missing not-taken branch: counter saturates.
        exp_cnt = 7;
        for (int i = 0; i < 20; i++) begin
            apply(mk(1, PA, 1, PA, 0, 0, 1, TA, 0,
                     0, 0, PA4, 1, PA4, CNT_W'(exp_cnt)),
                  $sformatf("sat%0d", i));
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
        end

        // Re-allocate, then a one-cycle reset drops a same-cycle update and clears state.
        apply(mk(1, PA, 1, PA, TA, 1, 0, 0,  0,   0, 0, PA4, 1, TA, 15), "realloc");
        apply(mk(1, PA, 0, 0,  0,  0, 0, 0,  0,   1, 1, TA,  0, 4,  15), "prerst");
        apply(mk(0, PA, 1, PB, TB, 1, 0, 0,  0,   0, 0, PA4, 1, TB, 15), "inrst");
        apply(mk(1, PA, 0, 0,  0,  0, 0, 0,  0,   0, 0, PA4, 0, 4,  0),  "postA");
        apply(mk(1, PB, 0, 0,  0,  0, 0, 0,  0,   0, 0, PB4, 0, 4,  0),  "postB");
        for (int k = 1; k < 8; k++) begin
            logic [31:0] pc;
            pc = PA + 32'(4 * k);
            apply(mk(1, pc, 0, 0, 0, 0, 0, 0, 0,  0, 0, pc + 32'd4, 0, 4, 0),
                  $sformatf("miss%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
